// File: rtl/scarv_soc_periph_arbiter.sv
// Two-requester arbiter sharing one peripheral memif target, with an in-flight ID FIFO
// that routes in-order responses back. Define PERIPH_ARB_RR_EN for round-robin, else r0 priority.
module scarv_soc_periph_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            r0_req,
    output logic            r0_gnt,
    input  logic            r0_wen,
    input  logic [DW/8-1:0] r0_strb,
    input  logic [AW-1:0]   r0_addr,
    input  logic [DW-1:0]   r0_wdata,
    input  logic            r0_recv,
    output logic            r0_ack,
    output logic            r0_error,
    output logic [DW-1:0]   r0_rdata,

    input  logic            r1_req,
    output logic            r1_gnt,
    input  logic            r1_wen,
    input  logic [DW/8-1:0] r1_strb,
    input  logic [AW-1:0]   r1_addr,
    input  logic [DW-1:0]   r1_wdata,
    input  logic            r1_recv,
    output logic            r1_ack,
    output logic            r1_error,
    output logic [DW-1:0]   r1_rdata,

    output logic            t_req,
    output logic            t_wen,
    output logic [DW/8-1:0] t_strb,
    output logic [AW-1:0]   t_addr,
    output logic [DW-1:0]   t_wdata,
    input  logic            t_gnt,
    output logic            t_recv,
    input  logic            t_ack,
    input  logic            t_error,
    input  logic [DW-1:0]   t_rdata,

    output logic            stray_rsp
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } own_state_e;

    own_state_e       state_q, state_d;
    logic             hold_sel_q, hold_sel_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stray_q, stray_d;
    logic [OUTSTANDING-1:0] id_mem_q;
`ifdef PERIPH_ARB_RR_EN
    logic             rr_last_q;
`endif

    logic sel;
    logic sel_req;
    logic fifo_full;
    logic fifo_empty;
    logic head;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requester selection: a held owner stays put until granted or it withdraws.
    always_comb begin
        sel = 1'b0;
        if (state_q == ST_HOLD) begin
            sel = hold_sel_q;
        end else if (r0_req && r1_req) begin
`ifdef PERIPH_ARB_RR_EN
            sel = ~rr_last_q;
`else
            sel = 1'b0;
`endif
        end else if (r1_req) begin
            sel = 1'b1;
        end
    end

    assign sel_req    = sel ? r1_req : r0_req;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(OUTSTANDING));

    assign t_req   = sel_req & ~fifo_full & ~g_reset;
    assign t_wen   = sel ? r1_wen   : r0_wen;
    assign t_strb  = sel ? r1_strb  : r0_strb;
    assign t_addr  = sel ? r1_addr  : r0_addr;
    assign t_wdata = sel ? r1_wdata : r0_wdata;

    assign push   = t_req & t_gnt;
    assign r0_gnt = push & ~sel;
    assign r1_gnt = push & sel;

    always_comb begin
        state_d    = state_q;
        hold_sel_d = hold_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (t_req && !t_gnt) begin
                    state_d    = ST_HOLD;
                    hold_sel_d = sel;
                end
            end
            ST_HOLD: begin
                if (!sel_req || push) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response routing follows the oldest outstanding ID.
    assign head   = id_mem_q[rd_ptr_q];
    assign t_recv = ~fifo_empty & (head ? r1_recv : r0_recv);
    assign pop    = t_ack & t_recv;

    assign r0_ack   = t_ack   & ~fifo_empty & ~head;
    assign r1_ack   = t_ack   & ~fifo_empty &  head;
    assign r0_error = t_error & ~fifo_empty & ~head;
    assign r1_error = t_error & ~fifo_empty &  head;
    assign r0_rdata = (~fifo_empty & ~head) ? t_rdata : '0;
    assign r1_rdata = (~fifo_empty &  head) ? t_rdata : '0;

    assign stray_d   = t_ack & fifo_empty;
    assign stray_rsp = stray_q;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q    <= ST_IDLE;
            hold_sel_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stray_q    <= 1'b0;
`ifdef PERIPH_ARB_RR_EN
            rr_last_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            hold_sel_q <= hold_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stray_q    <= stray_d;
`ifdef PERIPH_ARB_RR_EN
            if (push) begin
                rr_last_q <= sel;
            end
`endif
        end
    end

    // ID storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge g_clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_scarv_soc_periph_arbiter.sv
// Bench for scarv_soc_periph_arbiter: directed request stimulus, target responses
// tracked by a scoreboard of expected (requester, rdata) pairs.
module tb_scarv_soc_periph_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OUTSTANDING = 2;
`ifdef PERIPH_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic g_clk, g_reset;
    logic r0_req, r0_gnt, r0_wen, r0_recv, r0_ack, r0_error;
    logic [DW/8-1:0] r0_strb;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic r1_req, r1_gnt, r1_wen, r1_recv, r1_ack, r1_error;
    logic [DW/8-1:0] r1_strb;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic t_req, t_wen, t_gnt, t_recv, t_ack, t_error;
    logic [DW/8-1:0] t_strb;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic stray_rsp;

    scarv_soc_periph_arbiter #(.AW(AW), .DW(DW), .OUTSTANDING(OUTSTANDING)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_wen(r0_wen), .r0_strb(r0_strb),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_recv(r0_recv), .r0_ack(r0_ack),
        .r0_error(r0_error), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_wen(r1_wen), .r1_strb(r1_strb),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_recv(r1_recv), .r1_ack(r1_ack),
        .r1_error(r1_error), .r1_rdata(r1_rdata),
        .t_req(t_req), .t_wen(t_wen), .t_strb(t_strb), .t_addr(t_addr), .t_wdata(t_wdata),
        .t_gnt(t_gnt), .t_recv(t_recv), .t_ack(t_ack), .t_error(t_error), .t_rdata(t_rdata),
        .stray_rsp(stray_rsp)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tgt_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        chk_eq({tag, "_g0"}, r0_gnt, e0);
        chk_eq({tag, "_g1"}, r1_gnt, e1);
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r1_req = 1'b0;
        t_gnt = 1'b0; t_ack = 1'b0; t_error = 1'b0; t_rdata = '0;
    endtask

    task automatic set_req(input bit n, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
        if (!n) begin
            r0_req = 1'b1; r0_wen = wen; r0_strb = '1; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = 1'b1; r1_wen = wen; r1_strb = '1; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // Expected grant: record who should get the response and what the target will return.
    task automatic grant_push(input logic id, input logic [31:0] rdata);
        sb_q.push_back('{id, rdata});
        tgt_q.push_back(rdata);
    endtask

    task automatic respond();
        t_ack = 1'b1;
        t_error = 1'b0;
        t_rdata = (tgt_q.size() > 0) ? tgt_q.pop_front() : 32'hDEAD_0000;
    endtask

    always @(negedge g_clk) begin
        if (!g_reset && ((r0_ack && r0_recv) || (r1_ack && r1_recv))) begin
            chk_eq("rsp_onehot", r0_ack & r1_ack, 0);
            if (sb_q.size() == 0) begin
                chk_eq("rsp_unexpected", {r1_ack, r0_ack}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_eq("rsp_id", r1_ack, e.id);
                chk_eq("rsp_rdata", r1_ack ? r1_rdata : r0_rdata, e.data);
            end
        end
    end

    initial begin
        g_reset = 1'b1;
        r0_recv = 1'b1; r1_recv = 1'b1;
        r0_wen = 0; r0_strb = '0; r0_addr = '0; r0_wdata = '0;
        r1_wen = 0; r1_strb = '0; r1_addr = '0; r1_wdata = '0;
        idle_inputs();
        set_req(0, 1'b0, 32'h10, 32'h0);
        t_gnt = 1'b1; t_ack = 1'b1;
        #3;
        chk_eq("rst_t_req", t_req, 0);
        chk_gnt("rst", 0, 0);
        chk_eq("rst_r0_ack", r0_ack, 0);
        chk_eq("rst_r1_ack", r1_ack, 0);
        chk_eq("rst_t_recv", t_recv, 0);
        chk_eq("rst_stray", stray_rsp, 0);
        cyc(); cyc();
        chk_eq("rst_stray_held", stray_rsp, 0);
        idle_inputs();
        g_reset = 1'b0;
        cyc();

        // Single write from r0, granted immediately, acked next cycle
        set_req(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        t_gnt = 1'b1;
        #2;
        chk_eq("t1_t_req", t_req, 1);
        chk_eq("t1_addr", t_addr, 32'h1000_0004);
        chk_eq("t1_wen", t_wen, 1);
        chk_eq("t1_wdata", t_wdata, 32'hDEAD_BEEF);
        chk_eq("t1_strb", t_strb, 4'hF);
        chk_gnt("t1", 1, 0);
        grant_push(0, 32'h0);
        cyc();
        idle_inputs();
        respond();
        #2;
        chk_eq("t1_r0_ack", r0_ack, 1);
        chk_eq("t1_r0_err", r0_error, 0);
        chk_eq("t1_r1_ack", r1_ack, 0);
        chk_eq("t1_t_recv", t_recv, 1);
        cyc();
        idle_inputs();
        #2;
        chk_eq("t1_r1_ack_after", r1_ack, 0);
        chk_eq("t1_stray", stray_rsp, 0);
        chk_eq("t1_empty_recv", t_recv, 0);
        cyc();

        // Contention: arbitration policy with continuous grants
        g_reset = 1'b1;
        #2;
        g_reset = 1'b0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            logic e_id;
            set_req(0, 1'b0, 32'h2000_0000 + k, 32'h0);
            set_req(1, 1'b0, 32'h3000_0000 + k, 32'h0);
            r0_req = (k < 3);
            t_gnt = 1'b1;
            if (k > 0) respond();
            e_id = (k == 3) ? 1'b1 : (RR_EN ? k[0] : 1'b0);
            #2;
            chk_gnt($sformatf("t2_k%0d", k), ~e_id, e_id);
            chk_eq($sformatf("t2_addr_k%0d", k), t_addr,
                   e_id ? 32'h3000_0000 + k : 32'h2000_0000 + k);
            grant_push(e_id, 32'h2000 + k);
            cyc();
            t_ack = 1'b0;
        end
        idle_inputs();
        respond();
        cyc();
        idle_inputs();

        // Ownership hold while target stalls
        set_req(0, 1'b0, 32'h4000_0000, 32'h0);
        #2;
        chk_eq("t3_t_req", t_req, 1);
        chk_eq("t3_addr_c0", t_addr, 32'h4000_0000);
        chk_gnt("t3_c0", 0, 0);
        cyc();
        set_req(1, 1'b0, 32'h5000_0000, 32'h0);
        #2;
        chk_eq("t3_addr_c1", t_addr, 32'h4000_0000);
        chk_gnt("t3_c1", 0, 0);
        cyc();
        #2;
        chk_eq("t3_addr_c2", t_addr, 32'h4000_0000);
        cyc();
        t_gnt = 1'b1;
        #2;
        chk_gnt("t3_c3", 1, 0);
        chk_eq("t3_addr_c3", t_addr, 32'h4000_0000);
        grant_push(0, 32'h3333_0000);
        cyc();
        r0_req = 1'b0;
        #2;
        chk_gnt("t3_c4", 0, 1);
        chk_eq("t3_addr_c4", t_addr, 32'h5000_0000);
        grant_push(1, 32'h3333_0001);
        cyc();
        idle_inputs();
        respond();
        t_error = 1'b1;
        #2;
        chk_eq("t3_r0_err", r0_error, 1);
        chk_eq("t3_r1_err", r1_error, 0);
        cyc();
        respond();
        cyc();
        idle_inputs();
        set_req(1, 1'b0, 32'h5000_0010, 32'h0);
        #2;
        chk_eq("t3b_addr_c0", t_addr, 32'h5000_0010);
        cyc();
        set_req(0, 1'b0, 32'h4000_0010, 32'h0);
        #2;
        chk_eq("t3b_addr_c1", t_addr, 32'h5000_0010);
        chk_gnt("t3b_c1", 0, 0);
        cyc();
        t_gnt = 1'b1;
        #2;
        chk_gnt("t3b_c2", 0, 1);
        grant_push(1, 32'h3333_0010);
        cyc();
        r1_req = 1'b0;
        #2;
        chk_gnt("t3b_c3", 1, 0);
        grant_push(0, 32'h3333_0011);
        cyc();
        idle_inputs();
        respond();
        cyc();
        respond();
        cyc();
        idle_inputs();

        // FIFO full back-pressure and in-order routing
        set_req(0, 1'b0, 32'h6000_0000, 32'h0);
        t_gnt = 1'b1;
        #2;
        chk_gnt("t4_c0", 1, 0);
        grant_push(0, 32'hA5A5_0001);
        cyc();
        r0_req = 1'b0;
        set_req(1, 1'b0, 32'h6000_0004, 32'h0);
        #2;
        chk_gnt("t4_c1", 0, 1);
        grant_push(1, 32'hA5A5_0002);
        cyc();
        r1_req = 1'b0;
        set_req(0, 1'b0, 32'h6000_0008, 32'h0);
        #2;
        chk_eq("t4_full_t_req", t_req, 0);
        chk_gnt("t4_c2", 0, 0);
        cyc();
        r0_recv = 1'b0;
        t_ack = 1'b1;
        t_rdata = tgt_q[0];
        #2;
        chk_eq("t4_norecv_t_recv", t_recv, 0);
        chk_eq("t4_norecv_ack", r0_ack, 1);
        chk_eq("t4_c3_t_req", t_req, 0);
        cyc();
        r0_recv = 1'b1;
        respond();
        #2;
        chk_eq("t4_c4_r0_ack", r0_ack, 1);
        chk_eq("t4_c4_rdata", r0_rdata, 32'hA5A5_0001);
        chk_eq("t4_c4_t_req", t_req, 0);
        chk_gnt("t4_c4", 0, 0);
        cyc();
        respond();
        #2;
        chk_eq("t4_c5_r1_ack", r1_ack, 1);
        chk_eq("t4_c5_rdata", r1_rdata, 32'hA5A5_0002);
        chk_eq("t4_c5_r0_rdata", r0_rdata, 0);
        chk_gnt("t4_c5", 1, 0);
        grant_push(0, 32'hA5A5_0003);
        cyc();
        idle_inputs();
        respond();
        cyc();
        idle_inputs();

        // Stray response with nothing outstanding
        t_ack = 1'b1;
        t_rdata = 32'h1234_5678;
        #2;
        chk_eq("t5_r0_ack", r0_ack, 0);
        chk_eq("t5_r1_ack", r1_ack, 0);
        chk_eq("t5_t_recv", t_recv, 0);
        chk_eq("t5_stray_early", stray_rsp, 0);
        cyc();
        idle_inputs();
        #2;
        chk_eq("t5_stray", stray_rsp, 1);
        cyc();
        #2;
        chk_eq("t5_stray_clear", stray_rsp, 0);

        // Reset with transactions in flight
        set_req(0, 1'b0, 32'h7000_0000, 32'h0);
        t_gnt = 1'b1;
        #2;
        chk_gnt("t6_c0", 1, 0);
        grant_push(0, 32'h7777_0000);
        cyc();
        r0_req = 1'b0;
        set_req(1, 1'b0, 32'h7000_0004, 32'h0);
        #2;
        chk_gnt("t6_c1", 0, 1);
        grant_push(1, 32'h7777_0001);
        cyc();
        r1_req = 1'b0;
        set_req(0, 1'b0, 32'h7000_0008, 32'h0);
        #2;
        chk_eq("t6_pre_t_recv", t_recv, 1);
        g_reset = 1'b1;
        #1;
        chk_eq("t6_rst_t_req", t_req, 0);
        chk_eq("t6_rst_t_recv", t_recv, 0);
        chk_gnt("t6_rst", 0, 0);
        sb_q.delete();
        tgt_q.delete();
        cyc();
        g_reset = 1'b0;
        idle_inputs();
        cyc();
        t_ack = 1'b1;
        t_rdata = 32'h0BAD_0BAD;
        #2;
        chk_eq("t6_late_r0_ack", r0_ack, 0);
        chk_eq("t6_late_r1_ack", r1_ack, 0);
        cyc();
        t_ack = 1'b0;
        set_req(1, 1'b0, 32'h7000_0010, 32'h0);
        t_gnt = 1'b1;
        #2;
        chk_eq("t6_stray", stray_rsp, 1);
        chk_gnt("t6_after", 0, 1);
        grant_push(1, 32'h6666_0000);
        cyc();
        idle_inputs();
        respond();
        #2;
        chk_eq("t6_r1_ack", r1_ack, 1);
        cyc();
        idle_inputs();
        cyc();

        chk_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
